// File: rtl/axi_lite_addr_demux.sv
// One AXI4-Lite master fanned out to NUM_SLAVES slaves by address.
// Read and write paths are independent; unmapped accesses get a DECERR and bump dec_err_cnt.
module axi_lite_addr_demux #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int NUM_SLAVES = 8,
  parameter logic [NUM_SLAVES*AW-1:0] BASE_ADDR = {
    32'h1000_0000, 32'h4006_0000, 32'h4005_0000, 32'h4004_0000,
    32'h4003_0000, 32'h4002_0000, 32'h4001_0000, 32'h4000_0000},
  parameter logic [NUM_SLAVES*AW-1:0] ADDR_MASK = {
    32'hF000_0000, {7{32'hFFFF_0000}}},
  parameter int ERR_CNT_W  = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [AW-1:0]              m_AWADDR,
  input  logic                       m_AWVALID,
  output logic                       m_AWREADY,
  input  logic [DW-1:0]              m_WDATA,
  input  logic [DW/8-1:0]            m_WSTRB,
  input  logic                       m_WVALID,
  output logic                       m_WREADY,
  output logic [1:0]                 m_BRESP,
  output logic                       m_BVALID,
  input  logic                       m_BREADY,
  input  logic [AW-1:0]              m_ARADDR,
  input  logic                       m_ARVALID,
  output logic                       m_ARREADY,
  output logic [DW-1:0]              m_RDATA,
  output logic [1:0]                 m_RRESP,
  output logic                       m_RVALID,
  input  logic                       m_RREADY,
  output logic [NUM_SLAVES*AW-1:0]   s_AWADDR,
  output logic [NUM_SLAVES-1:0]      s_AWVALID,
  input  logic [NUM_SLAVES-1:0]      s_AWREADY,
  output logic [NUM_SLAVES*DW-1:0]   s_WDATA,
  output logic [NUM_SLAVES*DW/8-1:0] s_WSTRB,
  output logic [NUM_SLAVES-1:0]      s_WVALID,
  input  logic [NUM_SLAVES-1:0]      s_WREADY,
  input  logic [NUM_SLAVES*2-1:0]    s_BRESP,
  input  logic [NUM_SLAVES-1:0]      s_BVALID,
  output logic [NUM_SLAVES-1:0]      s_BREADY,
  output logic [NUM_SLAVES*AW-1:0]   s_ARADDR,
  output logic [NUM_SLAVES-1:0]      s_ARVALID,
  input  logic [NUM_SLAVES-1:0]      s_ARREADY,
  input  logic [NUM_SLAVES*DW-1:0]   s_RDATA,
  input  logic [NUM_SLAVES*2-1:0]    s_RRESP,
  input  logic [NUM_SLAVES-1:0]      s_RVALID,
  output logic [NUM_SLAVES-1:0]      s_RREADY,
  output logic [ERR_CNT_W-1:0]       dec_err_cnt
);

  // Handshake rule on every channel: a transfer happens on a rising ACLK edge where
  // VALID and READY are both high; VALID and its payload stay stable until then.

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_RESP, WR_ERR} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_RESP, RD_ERR} rd_state_e;

  wr_state_e            wr_state_q, wr_state_d;
  rd_state_e            rd_state_q, rd_state_d;
  logic [SEL_W-1:0]     wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 wr_err_inc, rd_err_inc;
  logic                 aw_hs, w_hs;
  logic [SEL_W:0]       aw_dec, ar_dec;
  logic [ERR_CNT_W:0]   err_sum;

  // Returns {hit, index}; scanning downwards lets the lowest matching index win.
  function automatic logic [SEL_W:0] decode(input logic [AW-1:0] addr);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASK[i*AW +: AW]) == BASE_ADDR[i*AW +: AW]) begin
        res = {1'b1, SEL_W'(i)};
      end
    end
    return res;
  endfunction

  assign aw_dec = decode(m_AWADDR);
  assign ar_dec = decode(m_ARADDR);

  assign s_AWADDR    = {NUM_SLAVES{wr_addr_q}};
  assign s_ARADDR    = {NUM_SLAVES{rd_addr_q}};
  assign s_WDATA     = {NUM_SLAVES{m_WDATA}};
  assign s_WSTRB     = {NUM_SLAVES{m_WSTRB}};
  assign dec_err_cnt = err_cnt_q;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_sel_d   = wr_sel_q;
    wr_addr_d  = wr_addr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    wr_err_inc = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (m_AWVALID) begin
          wr_addr_d  = m_AWADDR;
          wr_sel_d   = aw_dec[SEL_W] ? aw_dec[SEL_W-1:0] : '0;
          wr_state_d = aw_dec[SEL_W] ? WR_REQ : WR_ERR;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      WR_REQ: begin
        aw_hs = !aw_done_q && s_AWREADY[wr_sel_q];
        w_hs  = !w_done_q && m_WVALID && s_WREADY[wr_sel_q];
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        if (s_BVALID[wr_sel_q] && m_BREADY) wr_state_d = WR_IDLE;
      end
      WR_ERR: begin
        // The single W beat of an unmapped write is swallowed before B is offered.
        if (!w_done_q) begin
          if (m_WVALID) w_done_d = 1'b1;
        end else if (m_BREADY) begin
          wr_state_d = WR_IDLE;
          wr_err_inc = 1'b1;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_sel_d   = rd_sel_q;
    rd_addr_d  = rd_addr_q;
    rd_err_inc = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (m_ARVALID) begin
          rd_addr_d  = m_ARADDR;
          rd_sel_d   = ar_dec[SEL_W] ? ar_dec[SEL_W-1:0] : '0;
          rd_state_d = ar_dec[SEL_W] ? RD_REQ : RD_ERR;
        end
      end
      RD_REQ:  if (s_ARREADY[rd_sel_q]) rd_state_d = RD_RESP;
      RD_RESP: if (s_RVALID[rd_sel_q] && m_RREADY) rd_state_d = RD_IDLE;
      RD_ERR: begin
        if (m_RREADY) begin
          rd_state_d = RD_IDLE;
          rd_err_inc = 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // A read and a write DECERR can retire together; the extra carry bit detects saturation.
  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + (ERR_CNT_W+1)'(wr_err_inc) + (ERR_CNT_W+1)'(rd_err_inc);
    err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
  end

  always_comb begin
    m_AWREADY = (wr_state_q == WR_IDLE) && !ARESET;
    m_ARREADY = (rd_state_q == RD_IDLE) && !ARESET;
    m_WREADY  = 1'b0;
    m_BVALID  = 1'b0;
    m_BRESP   = 2'b00;
    m_RVALID  = 1'b0;
    m_RDATA   = '0;
    m_RRESP   = 2'b00;
    s_AWVALID = '0;
    s_WVALID  = '0;
    s_BREADY  = '0;
    s_ARVALID = '0;
    s_RREADY  = '0;
    case (wr_state_q)
      WR_REQ: begin
        s_AWVALID[wr_sel_q] = !aw_done_q;
        s_WVALID[wr_sel_q]  = m_WVALID && !w_done_q;
        m_WREADY            = s_WREADY[wr_sel_q] && !w_done_q;
      end
      WR_RESP: begin
        m_BVALID           = s_BVALID[wr_sel_q];
        m_BRESP            = s_BRESP[wr_sel_q*2 +: 2];
        s_BREADY[wr_sel_q] = m_BREADY;
      end
      WR_ERR: begin
        m_WREADY = !w_done_q;
        m_BVALID = w_done_q;
        m_BRESP  = RESP_DECERR;
      end
      default: ;
    endcase
    case (rd_state_q)
      RD_REQ: s_ARVALID[rd_sel_q] = 1'b1;
      RD_RESP: begin
        m_RVALID           = s_RVALID[rd_sel_q];
        m_RDATA            = s_RDATA[rd_sel_q*DW +: DW];
        m_RRESP            = s_RRESP[rd_sel_q*2 +: 2];
        s_RREADY[rd_sel_q] = m_RREADY;
      end
      RD_ERR: begin
        m_RVALID = 1'b1;
        m_RRESP  = RESP_DECERR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      wr_sel_q   <= '0;
      rd_sel_q   <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule
